// File: rtl/pmem_line_responder_pkg.sv
// Shared types and defaults for the line-granular memory responder.
package pmem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int DEF_LINE_BITS  = 256;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_LATENCY    = 4;
  localparam int CNT_W          = 8;

  // Byte-offset width of a line address.
  function automatic int offset_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

endpackage

// File: rtl/pmem_line_responder_if.sv
// Line-granular physical memory port between the L2 controller and memory.
interface pmem_line_responder_if #(
  parameter int LINE_BITS  = 256,
  parameter int ADDR_WIDTH = 32
);
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_BITS-1:0]  pmem_wdata;
  logic [LINE_BITS-1:0]  pmem_rdata;
  logic                  pmem_resp;
  logic                  busy;
  logic                  proto_err;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp, busy, proto_err
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp, busy, proto_err
  );
endinterface

// File: rtl/pmem_line_responder_array.sv
// Single-port line storage with synchronous write and registered read; no reset.
module pmem_line_array #(
  parameter int LINE_BITS  = 256,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] addr,
  input  logic [LINE_BITS-1:0]  wdata,
  output logic [LINE_BITS-1:0]  rdata
);
  logic [LINE_BITS-1:0] mem [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/pmem_line_responder.sv
// Memory-side responder: accepts one line request, services it after LATENCY
// wait cycles, and pulses pmem_resp for one cycle.
module pmem_line_responder
  import pmem_resp_pkg::*;
#(
  parameter int LINE_BITS  = DEF_LINE_BITS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int LATENCY    = DEF_LATENCY
) (
  input logic                  clk,
  input logic                  rst_n,
  pmem_line_responder_if.slave bus
);
  localparam int OFFSET_BITS = offset_bits(LINE_BITS);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [INDEX_BITS-1:0] idx_q;
  logic                  op_wr_q;
  logic [LINE_BITS-1:0]  wdata_q;
  logic                  proto_err_q;
  logic                  rd_vld_q;
  logic                  req, accept, commit;
  logic                  arr_we, arr_re;
  logic [LINE_BITS-1:0]  arr_rdata;
  logic                  unused_addr;

  assign req    = bus.pmem_read | bus.pmem_write;
  assign accept = (state == IDLE) && req;
  assign commit = (state == WAIT) && (cnt == '0);
  assign arr_we = commit & op_wr_q;
  assign arr_re = commit & ~op_wr_q;

  // Bits outside the index field never select anything: offset and alias bits.
  assign unused_addr = ^{bus.pmem_address[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS],
                         bus.pmem_address[OFFSET_BITS-1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req) begin
        state_nxt = WAIT;
        cnt_nxt   = CNT_W'(LATENCY - 1);
      end
      WAIT: if (cnt == '0) state_nxt = RESP;
            else           cnt_nxt   = cnt - CNT_W'(1);
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Read wins when both lines are high; the write is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      op_wr_q     <= 1'b0;
      wdata_q     <= '0;
      proto_err_q <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      if (accept) begin
        idx_q   <= bus.pmem_address[OFFSET_BITS +: INDEX_BITS];
        op_wr_q <= bus.pmem_write & ~bus.pmem_read;
        wdata_q <= bus.pmem_wdata;
        if (bus.pmem_read && bus.pmem_write) proto_err_q <= 1'b1;
      end
      if (arr_re) rd_vld_q <= 1'b1;
    end
  end

  pmem_line_array #(
    .LINE_BITS (LINE_BITS),
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  // The array output has no reset, so rdata reads as zero until the first read lands.
  assign bus.pmem_rdata = rd_vld_q ? arr_rdata : '0;
  assign bus.pmem_resp  = (state == RESP);
  assign bus.busy       = (state != IDLE);
  assign bus.proto_err  = proto_err_q;
endmodule
